adam_pause_sequencer: RTL

//  Orders the pause/resume handshake across NO_TGTS pausable blocks (fabrics, bridges, peripherals).
//  - One upstream 4-phase pause_req/pause_ack pair fans out into per-target pairs.
//  - Pause runs target 0 -> NO_TGTS-1; resume runs in reverse. Example: APB side quiesces before the
//    AXI-Lite side that feeds it.
//  - Sits between the system power/reset controller and the fabric instances.

---
 rtl/adam_pause_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/adam_pause_sequencer.sv
// rtl/adam_pause_sequencer.sv - ordered 4-phase pause/resume fan-out across NO_TGTS targets
module adam_pause_sequencer #(
  parameter int NO_TGTS   = 8,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1,
  parameter int IDX_WIDTH = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause_req,
  output logic                 pause_ack,
  output logic [NO_TGTS-1:0]   tgt_pause_req,
  input  logic [NO_TGTS-1:0]   tgt_pause_ack,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [IDX_WIDTH-1:0] err_idx
);

  localparam logic [1:0] ST_RUNNING  = 2'd0;
  localparam logic [1:0] ST_PAUSING  = 2'd1;
  localparam logic [1:0] ST_PAUSED   = 2'd2;
  localparam logic [1:0] ST_RESUMING = 2'd3;

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NO_TGTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);

  logic [1:0]           state_q, state_n;
  logic [IDX_WIDTH-1:0] idx_q, idx_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic [NO_TGTS-1:0]   req_q, req_n;
  logic                 ack_q, ack_n;
  logic                 busy_q;
  logic                 err_q, err_n;
  logic [IDX_WIDTH-1:0] err_idx_q, err_idx_n;
  logic                 ack_hit;
  logic                 wait_cycle;

  // Next-state logic: walk idx up while pausing, down while resuming; a target's
  // req only ever changes after its previous transition has been acknowledged.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    cnt_n      = cnt_q;
    req_n      = req_q;
    ack_n      = ack_q;
    err_n      = err_q;
    err_idx_n  = err_idx_q;
    wait_cycle = 1'b0;
    // Pausing waits for ack high, resuming waits for ack low.
    ack_hit    = (tgt_pause_ack[idx_q] == (state_q == ST_PAUSING));

    case (state_q)
      ST_RUNNING: begin
        if (pause_req) begin
          state_n  = ST_PAUSING;
          idx_n    = '0;
          cnt_n    = '0;
          req_n[0] = 1'b1;
        end
      end
      ST_PAUSING: begin
        if (ack_hit) begin
          cnt_n = '0;
          if (!pause_req) begin
            // Abort: unwind from the target that just acked.
            state_n      = ST_RESUMING;
            req_n[idx_q] = 1'b0;
          end else if (idx_q == IDX_LAST) begin
            state_n = ST_PAUSED;
            ack_n   = 1'b1;
          end else begin
            idx_n        = idx_q + IDX_WIDTH'(1);
            req_n[idx_n] = 1'b1;
          end
        end else begin
          wait_cycle = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (!pause_req) begin
          state_n         = ST_RESUMING;
          idx_n           = IDX_LAST;
          cnt_n           = '0;
          req_n[IDX_LAST] = 1'b0;
        end
      end
      default: begin
        if (ack_hit) begin
          cnt_n = '0;
          if (pause_req) begin
            // Re-pause: the deassert has completed, so re-request this target.
            state_n      = ST_PAUSING;
            req_n[idx_q] = 1'b1;
          end else if (idx_q != '0) begin
            idx_n        = idx_q - IDX_WIDTH'(1);
            req_n[idx_n] = 1'b0;
          end else begin
            state_n = ST_RUNNING;
            ack_n   = 1'b0;
          end
        end else begin
          wait_cycle = 1'b1;
        end
      end
    endcase

    // Watchdog on the current target: flag once, keep waiting, remember the first culprit.
    if ((TIMEOUT != 0) && wait_cycle && (cnt_q != CNT_MAX)) begin
      cnt_n = cnt_q + CNT_WIDTH'(1);
      if (cnt_n == CNT_MAX) begin
        err_n = 1'b1;
        if (!err_q) begin
          err_idx_n = idx_q;
        end
      end
    end
  end

  // State and registered outputs; reset drops every target request on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUNNING;
      idx_q     <= '0;
      cnt_q     <= '0;
      req_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      req_q     <= req_n;
      ack_q     <= ack_n;
      busy_q    <= (state_n == ST_PAUSING) || (state_n == ST_RESUMING);
      err_q     <= err_n;
      err_idx_q <= err_idx_n;
    end
  end

  assign pause_ack     = ack_q;
  assign tgt_pause_req = req_q;
  assign busy          = busy_q;
  assign timeout_err   = err_q;
  assign err_idx       = err_idx_q;

endmodule
